// File: rtl/ibex_pkg.sv
// Shared ibex types and constants.
// Regfile address widths and the write-port bundle.
package ibex_pkg;

  localparam int unsigned RegfileAddrW  = 5;
  localparam int unsigned RegfileAddrWE = 4;
  localparam int unsigned RegfileDataW  = 32;

  typedef struct packed {
    logic [RegfileAddrW-1:0] addr;
    logic [RegfileDataW-1:0] data;
    logic                    we;
  } regfile_wport_t;

endpackage

// File: rtl/ibex_regfile_sb_busy.sv
// Per-register busy scoreboard for long-latency writebacks.
// Tracks reservations and detects read/WAW hazards.
module ibex_regfile_sb_busy
  import ibex_pkg::*;
#(
  parameter int unsigned AddrW        = 5,
  parameter int unsigned NumReadPorts = 2,
  parameter bit          WriteThrough = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReadPorts*AddrW-1:0] raddr_i,
  input  logic [NumReadPorts-1:0]       rreq_i,
  input  logic                          rsv_valid_i,
  input  logic [AddrW-1:0]              rsv_addr_i,
  input  logic                          wb_valid_i,
  input  logic [AddrW-1:0]              wb_addr_i,
  output logic [2**AddrW-1:0]           busy_o,
  output logic                          stall_o
);

  localparam int unsigned NumRegs = 2**AddrW;

  logic [NumRegs-1:0] busy_d, busy_q;
  logic [AddrW-1:0]   ra;
  logic               rd_haz, waw_haz, rsv_go;

  always_comb begin
    rd_haz = 1'b0;
    ra     = '0;
    for (int k = 0; k < NumReadPorts; k++) begin
      ra = raddr_i[k*AddrW +: AddrW];
      if (rreq_i[k] && (ra != '0) && busy_q[ra] &&
          !(WriteThrough && wb_valid_i && (wb_addr_i == ra))) begin
        rd_haz = 1'b1;
      end
    end
  end

  assign waw_haz = rsv_valid_i && (rsv_addr_i != '0) &&
                   busy_q[rsv_addr_i] &&
                   !(wb_valid_i && (wb_addr_i == rsv_addr_i));

  assign stall_o = rd_haz | waw_haz;
  assign rsv_go  = rsv_valid_i & ~stall_o;

  // A new reservation outranks the writeback of the previous one.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NumRegs; r++) begin
      busy_d[r] = (rsv_go && (rsv_addr_i == AddrW'(r))) ||
                  (busy_q[r] &&
                   !(wb_valid_i && (wb_addr_i == AddrW'(r))));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/ibex_regfile_scoreboard.sv
// Flip-flop register file with N read ports, two write ports
// and a busy scoreboard driving the ID stall.
module ibex_regfile_scoreboard
  import ibex_pkg::*;
#(
  parameter bit          RV32E             = 1'b0,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumReadPorts      = 2,
  parameter bit          WriteThrough      = 1'b1,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              dummy_instr_id_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  input  logic [NumReadPorts-1:0]           rreq_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [4:0]                        waddr_a_i,
  input  logic [DataWidth-1:0]              wdata_a_i,
  input  logic                              we_a_i,
  input  logic                              rsv_valid_i,
  input  logic [4:0]                        rsv_addr_i,
  input  logic                              wb_valid_i,
  input  logic [4:0]                        wb_addr_i,
  input  logic [DataWidth-1:0]              wb_data_i,
  output logic                              reg_stall_o,
  output logic [(RV32E ? 16 : 32)-1:0]      busy_o
);

  localparam int unsigned AW =
    RV32E ? RegfileAddrWE : RegfileAddrW;
  localparam int unsigned NumRegs = 2**AW;
  localparam logic [4:0] AMask = 5'(NumRegs - 1);

  regfile_wport_t       wp_a, wp_b;
  logic                 x0_wr_ok;
  logic [DataWidth-1:0] rf_q [NumRegs];
  logic [DataWidth-1:0] rf_d [NumRegs];
  logic [DataWidth-1:0] rd;
  logic [4:0]           ra;
  logic [NumReadPorts*AW-1:0] raddr_sb;

  assign x0_wr_ok = DummyInstructions & dummy_instr_id_i;

  always_comb begin
    wp_a      = '0;
    wp_a.addr = waddr_a_i & AMask;
    wp_a.data[DataWidth-1:0] = wdata_a_i;
    wp_a.we   = we_a_i & ((wp_a.addr != '0) | x0_wr_ok);
    wp_b      = '0;
    wp_b.addr = wb_addr_i & AMask;
    wp_b.data[DataWidth-1:0] = wb_data_i;
    wp_b.we   = wb_valid_i & ((wp_b.addr != '0) | x0_wr_ok);
  end

  // Port A wins a same-address collision.
  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      rf_d[r] = rf_q[r];
      if (wp_a.we && (wp_a.addr == 5'(r))) begin
        rf_d[r] = wp_a.data[DataWidth-1:0];
      end else if (wp_b.we && (wp_b.addr == 5'(r))) begin
        rf_d[r] = wp_b.data[DataWidth-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rdata_o  = '0;
    raddr_sb = '0;
    rd       = '0;
    ra       = '0;
    for (int k = 0; k < NumReadPorts; k++) begin
      ra = raddr_i[k*5 +: 5] & AMask;
      raddr_sb[k*AW +: AW] = ra[AW-1:0];
      rd = rf_q[ra[AW-1:0]];
      if (WriteThrough) begin
        if (wp_a.we && (wp_a.addr == ra)) begin
          rd = wp_a.data[DataWidth-1:0];
        end else if (wp_b.we && (wp_b.addr == ra)) begin
          rd = wp_b.data[DataWidth-1:0];
        end
      end
      if ((ra == '0) && !dummy_instr_id_i) begin
        rd = '0;
      end
      rdata_o[k*DataWidth +: DataWidth] = rd;
    end
  end

  ibex_regfile_sb_busy #(
    .AddrW        (AW),
    .NumReadPorts (NumReadPorts),
    .WriteThrough (WriteThrough)
  ) u_busy (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .raddr_i     (raddr_sb),
    .rreq_i      (rreq_i),
    .rsv_valid_i (rsv_valid_i),
    .rsv_addr_i  (rsv_addr_i[AW-1:0]),
    .wb_valid_i  (wb_valid_i),
    .wb_addr_i   (wb_addr_i[AW-1:0]),
    .busy_o      (busy_o),
    .stall_o     (reg_stall_o)
  );

endmodule

// File: tb/tb_ibex_regfile_scoreboard.sv
// Bench for ibex_regfile_scoreboard: write-through, no-write-through
// and RV32E variants driven by the same stimulus.
module tb_ibex_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dummy;
  logic [9:0]  raddr;
  logic [1:0]  rreq;
  logic [4:0]  waddr_a, rsv_addr, wb_addr;
  logic [31:0] wdata_a, wb_data;
  logic        we_a, rsv_valid, wb_valid;

  logic [63:0] rd_w, rd_n, rd_e;
  logic        st_w, st_n, st_e;
  logic [31:0] busy_w, busy_n;
  logic [15:0] busy_e;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ibex_regfile_scoreboard u_dut (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy),
    .raddr_i(raddr), .rreq_i(rreq), .rdata_o(rd_w),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .reg_stall_o(st_w), .busy_o(busy_w)
  );

  ibex_regfile_scoreboard #(.WriteThrough(1'b0)) u_nwt (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy),
    .raddr_i(raddr), .rreq_i(rreq), .rdata_o(rd_n),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .reg_stall_o(st_n), .busy_o(busy_n)
  );

  ibex_regfile_scoreboard #(.RV32E(1'b1)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy),
    .raddr_i(raddr), .rreq_i(rreq), .rdata_o(rd_e),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .reg_stall_o(st_e), .busy_o(busy_e)
  );

  typedef struct {
    logic        we_a;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wb;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] en0;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    dummy = 0; raddr = '0; rreq = '0;
    waddr_a = '0; wdata_a = '0; we_a = 0;
    rsv_valid = 0; rsv_addr = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // we_a wa wd wb ba bd r0 r1 e0 e1 en0
    vt[0] = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 5, 0,
              32'hDEADBEEF, 0, 0};
    vt[1] = '{0, 0,  0, 0, 0, 0, 5, 9,
              32'hDEADBEEF, 0, 32'hDEADBEEF};
    vt[2] = '{1, 9,  32'hAAAA, 1, 9, 32'h5555, 9, 9,
              32'hAAAA, 32'hAAAA, 0};
    vt[3] = '{0, 0,  0, 0, 0, 0, 9, 9,
              32'hAAAA, 32'hAAAA, 32'hAAAA};
    vt[4] = '{1, 0,  32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{0, 0,  0, 0, 0, 0, 0, 5,
              0, 32'hDEADBEEF, 0};
    vt[6] = '{0, 0,  0, 1, 12, 32'h77, 12, 9,
              32'h77, 32'hAAAA, 0};
    vt[7] = '{0, 0,  0, 0, 0, 0, 12, 9,
              32'h77, 32'hAAAA, 32'h77};

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Reset state across all addresses
    @(negedge clk);
    chk("rst_stall", st_w, 0);
    chk("rst_busy", busy_w, 0);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      chk("rst_rdata", rd_w, 0);
    end
    step();
    idle();

    for (int i = 0; i < 8; i++) begin
      we_a = vt[i].we_a; waddr_a = vt[i].wa; wdata_a = vt[i].wd;
      wb_valid = vt[i].wb; wb_addr = vt[i].ba; wb_data = vt[i].bd;
      raddr = {vt[i].r1, vt[i].r0};
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), rd_w[31:0], vt[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_w[63:32], vt[i].e1);
      chk($sformatf("vec%0d_nwt", i), rd_n[31:0], vt[i].en0);
      chk($sformatf("vec%0d_stall", i), st_w, 0);
      step();
      idle();
    end

    // Read hazard on a reserved register
    rsv_valid = 1; rsv_addr = 7;
    @(negedge clk);
    chk("rsv7_stall", st_w, 0);
    step();
    idle();
    rreq = 2'b01; raddr[4:0] = 7;
    repeat (3) begin
      @(negedge clk);
      chk("haz7_stall", st_w, 1);
      chk("haz7_busy", busy_w[7], 1);
      step();
    end
    wb_valid = 1; wb_addr = 7; wb_data = 32'h1234;
    @(negedge clk);
    chk("wb7_stall", st_w, 0);
    chk("wb7_rdata", rd_w[31:0], 32'h1234);
    chk("wb7_nwt_stall", st_n, 1);
    step();
    idle();
    raddr[4:0] = 7;
    @(negedge clk);
    chk("wb7_busy", busy_w[7], 0);
    chk("wb7_nwt_rdata", rd_n[31:0], 32'h1234);
    step();
    idle();

    // Scoreboard corner cases
    rsv_valid = 1; rsv_addr = 3;
    step();
    idle();
    rsv_valid = 1; rsv_addr = 3;
    @(negedge clk);
    chk("waw3_busy", busy_w[3], 1);
    chk("waw3_stall", st_w, 1);
    step();
    idle();
    rsv_valid = 1; rsv_addr = 4; rreq = 2'b01; raddr[4:0] = 3;
    @(negedge clk);
    chk("rsv4_stall", st_w, 1);
    step();
    idle();
    @(negedge clk);
    chk("rsv4_dropped", busy_w[4], 0);
    step();
    rsv_valid = 1; rsv_addr = 3;
    wb_valid = 1; wb_addr = 3; wb_data = 32'h33;
    @(negedge clk);
    chk("setclr3_stall", st_w, 0);
    step();
    idle();
    @(negedge clk);
    chk("setclr3_busy", busy_w, 32'h8);
    step();
    wb_valid = 1; wb_addr = 3; wb_data = 32'h34;
    step();
    idle();
    @(negedge clk);
    chk("clr3_busy", busy_w, 0);
    step();

    // RV32E, mid-reservation reset
    rsv_valid = 1; rsv_addr = 5;
    step();
    idle();
    raddr[4:0] = 5;
    @(negedge clk);
    chk("e_busy5", busy_e[5], 1);
    rst_n = 0;
    #1;
    chk("e_rst_busy", busy_e, 0);
    chk("w_rst_busy", busy_w, 0);
    chk("e_rst_rdata", rd_e, 0);
    @(posedge clk);
    #1 rst_n = 1;
    we_a = 1; waddr_a = 5'd17; wdata_a = 32'h1111;
    step();
    idle();
    raddr = {5'd17, 5'd1};
    @(negedge clk);
    chk("e_x17_to_x1", rd_e[31:0], 32'h1111);
    chk("e_x17_alias", rd_e[63:32], 32'h1111);
    chk("w_x1", rd_w[31:0], 0);
    chk("w_x17", rd_w[63:32], 32'h1111);
    step();
    idle();
    wb_valid = 1; wb_addr = 1; wb_data = 32'h2222;
    rreq = 2'b01; raddr[4:0] = 1;
    @(negedge clk);
    chk("e_wb1_stall", st_e, 0);
    chk("e_wb1_fwd", rd_e[31:0], 32'h2222);
    step();
    idle();
    raddr[4:0] = 1;
    @(negedge clk);
    chk("e_wb1_rdata", rd_e[31:0], 32'h2222);
    chk("e_wb1_busy", busy_e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
